// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    WRITE,
    RUN,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into a 32-bit word; full flags a complete word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full,
  output logic        last
);

  logic [$clog2(BYTES_PER_WORD)-1:0] lane;

  // The next push completes the word; lets the FSM leave LOAD on that same edge.
  assign last = (lane == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
      word <= '0;
      full <= 1'b0;
    end else if (clr) begin
      lane <= '0;
      word <= '0;
      full <= 1'b0;
    end else if (push) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
      lane                      <= lane + 2'd1;
      full                      <= last;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Holds the core in reset while a length-prefixed byte stream is written into imem.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// HDR0  | expecting word count low byte
// HDR1  | expecting word count high byte, validates the count
// LOAD  | collecting the four bytes of the current word
// WRITE | one-cycle imem write strobe
// RUN   | program loaded, core released
// ERR   | bad count, held until reset
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_t state, state_n;

  logic [8*HDR_BYTES-1:0] count;
  logic [15:0]            hdr_count;
  logic [16:0]            wl_next;
  logic                   xfer, start_ok, last_word;
  logic                   pk_full, pk_last;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && (state == IDLE || state == RUN);
  assign hdr_count = {byte_data, count[7:0]};
  assign wl_next   = 17'(words_loaded) + 17'd1;
  assign last_word = (wl_next == {1'b0, count});

  byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_ok),
    .push    (xfer && state == LOAD),
    .byte_in (byte_data),
    .word    (imem_wd),
    .full    (pk_full),
    .last    (pk_last)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = HDR0;
      HDR0:    if (xfer) state_n = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_count == 16'd0)                state_n = RUN;
          else if (hdr_count > 16'(MAX_WORDS))   state_n = ERR;
          else                                   state_n = LOAD;
        end
      end
      LOAD:    if (xfer && pk_last) state_n = WRITE;
      WRITE:   if (pk_full) state_n = last_word ? RUN : LOAD;
      RUN:     if (start_ok) state_n = HDR0;
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      imem_addr    <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      loading      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state      <= state_n;
      cpu_reset  <= (state_n != RUN);
      byte_ready <= (state_n inside {HDR0, HDR1, LOAD});
      imem_we    <= (state_n == WRITE);
      loading    <= (state_n inside {HDR0, HDR1, LOAD, WRITE});
      done       <= (state_n == RUN);
      error      <= (state_n == ERR);

      if (start_ok) begin
        imem_addr    <= '0;
        words_loaded <= '0;
      end
      if (state == HDR0 && xfer) count[7:0]  <= byte_data;
      if (state == HDR1 && xfer) count[15:8] <= byte_data;
      if (state == WRITE && pk_full) begin
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
        if (state_n == LOAD) imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a byte-stream reference model checked every cycle.
module tb_prog_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, imem_we, cpu_reset, loading, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_pulses = 0;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wd      (imem_wd),
    .cpu_reset    (cpu_reset),
    .loading      (loading),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 run, 3 error.
  int          m_phase = 0;
  int          m_hdr = 0;
  int          m_count = 0;
  int          m_lane = 0;
  int          m_written = 0;
  logic        m_due = 1'b0;
  logic [7:0]  m_b0 = 8'h00;
  logic [31:0] m_word = '0;
  logic [31:0] m_exp = '0;
  logic [31:0] tb_mem [0:255];

  always @(negedge clk) begin
    #2;
    if (reset) begin
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wd", imem_wd, 0);
      chk("rst_loading", loading, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_words_loaded", words_loaded, 0);
      m_phase = 0; m_hdr = 0; m_lane = 0; m_written = 0; m_due = 1'b0;
    end else begin
      chk("cpu_reset", cpu_reset, m_phase != 2);
      chk("done", done, m_phase == 2);
      chk("error", error, m_phase == 3);
      chk("loading", loading, m_phase == 1);
      chk("byte_ready", byte_ready, m_phase == 1 && !m_due);
      chk("imem_we", imem_we, m_due);
      chk("words_loaded", words_loaded, m_written);
      if (imem_we) begin
        we_pulses++;
        tb_mem[imem_addr] = imem_wd;
      end
      if (m_due) begin
        chk("write_addr", imem_addr, m_written);
        chk("write_data", imem_wd, m_exp);
        m_written++;
        m_due = 1'b0;
        if (m_written == m_count) m_phase = 2;
      end else if (start && (m_phase == 0 || m_phase == 2)) begin
        m_phase = 1; m_hdr = 0; m_lane = 0; m_written = 0;
      end else if (m_phase == 1 && byte_valid) begin
        if (m_hdr == 0) begin
          m_b0 = byte_data;
          m_hdr = 1;
        end else if (m_hdr == 1) begin
          m_count = int'(byte_data) * 256 + int'(m_b0);
          m_hdr = 2;
          if (m_count == 0) m_phase = 2;
          else if (m_count > MAX_WORDS) m_phase = 3;
        end else begin
          m_word[8*m_lane +: 8] = byte_data;
          m_lane++;
          if (m_lane == 4) begin
            m_exp = m_word;
            m_due = 1'b1;
            m_lane = 0;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) chk("byte_ready_timeout", byte_ready, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send_byte(q[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_run(output int r);
    int n;
    n = 0;
    while (cpu_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cpu_reset) chk("run_timeout", cpu_reset, 0);
    r = cyc;
  endtask

  initial begin
    logic [7:0] bq[$];
    int s, r, wp;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load, no stalls.
    pulse_start(s);
    bq = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(bq, 0);
    wait_run(r);
    chk("t1_latency", r - s, 12);
    chk("t1_mem0", tb_mem[0], 32'h12345678);
    chk("t1_mem1", tb_mem[1], 32'hDEADBEEF);
    chk("t1_words_loaded", words_loaded, 2);
    chk("t1_done", done, 1);

    // Reload from RUN overwrites from address 0.
    pulse_start(s);
    chk("t6_cpu_reset_up", cpu_reset, 1);
    chk("t6_words_cleared", words_loaded, 0);
    bq = {8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_seq(bq, 0);
    wait_run(r);
    chk("t6_mem0", tb_mem[0], 32'hCAFEF00D);
    chk("t6_mem1_kept", tb_mem[1], 32'hDEADBEEF);

    // Empty program.
    wp = we_pulses;
    pulse_start(s);
    bq = {8'h00, 8'h00};
    send_seq(bq, 0);
    wait_run(r);
    chk("t2_latency", r - s, 2);
    chk("t2_no_write", we_pulses - wp, 0);
    chk("t2_words_loaded", words_loaded, 0);

    // Three words with random host gaps.
    pulse_start(s);
    bq = {8'h03, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04, 8'h03, 8'h02, 8'h01,
          8'hC0, 8'hD0, 8'hE0, 8'hF0};
    send_seq(bq, 5);
    wait_run(r);
    chk("t4_mem0", tb_mem[0], 32'hA1B2C3D4);
    chk("t4_mem1", tb_mem[1], 32'h01020304);
    chk("t4_mem2", tb_mem[2], 32'hF0E0D0C0);
    chk("t4_words_loaded", words_loaded, 3);

    // Reset after the second data byte, then a fresh one-word load.
    wp = we_pulses;
    pulse_start(s);
    bq = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq(bq, 0);
    reset = 1'b1;
    #2;
    chk("t5_async_cpu_reset", cpu_reset, 1);
    chk("t5_async_loading", loading, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_no_write_on_abort", we_pulses - wp, 0);
    @(negedge clk);
    pulse_start(s);
    bq = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_seq(bq, 0);
    wait_run(r);
    chk("t5_mem0", tb_mem[0], 32'h11223344);
    chk("t5_mem1_kept", tb_mem[1], 32'h01020304);
    chk("t5_one_write", we_pulses - wp, 1);

    // Oversized count lands in ERR; start is ignored there.
    pulse_start(s);
    bq = {8'h01, 8'h01};
    send_seq(bq, 0);
    repeat (2) @(negedge clk);
    chk("t3_error", error, 1);
    chk("t3_cpu_reset", cpu_reset, 1);
    pulse_start(s);
    repeat (3) @(negedge clk);
    chk("t3_error_held", error, 1);
    chk("t3_not_loading", loading, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t3_error_cleared", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sequences the instruction memory and the ARM core. It holds the processor in reset while a byte stream (from a UART receiver or test host) is packed little-endian into 32-bit words and written into the instruction memory's write port. After the programmed word count has been stored, it releases the core. It sits between the host byte source, the `imem` write port and the `arm` reset input in the top level.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `MAX_WORDS`, 256: largest accepted program length in words; must be ≤ 2**ADDR_W.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset of the whole block.
- `start`  in  1  one-cycle pulse; begins a (re)load from IDLE or RUN; ignored in other states.
- `byte_valid`  in  1  host byte available.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts `byte_data` this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wd`  out  32  word to write.
- `cpu_reset`  out  1  reset to the core; high except in RUN.
- `loading`  out  1  high in HDR0, HDR1, LOAD and WRITE.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR.
- `words_loaded`  out  ADDR_W+1  words written since the last `start`.

## Operation
- States: IDLE, HDR0, HDR1, LOAD, WRITE, RUN, ERR.
- IDLE: `cpu_reset`=1. A `start` pulse moves to HDR0, clears `words_loaded`, the byte lane counter and `imem_addr`.
- HDR0: accepts one byte as count[7:0] and moves to HDR1.
- HDR1: accepts one byte as count[15:8]. On that transfer:
  - count = 0 → RUN.
  - count > MAX_WORDS → ERR.
  - otherwise → LOAD.
- LOAD: accepts bytes. Lane 0..3 fill `imem_wd[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` respectively (little-endian). Accepting lane 3 moves to WRITE.
- WRITE: `imem_we`=1 for exactly one cycle with the assembled word at `imem_addr`. Next state:
  - if `words_loaded`+1 == count → RUN;
  - else LOAD, with `imem_addr`+1 and `words_loaded`+1.
- RUN: `cpu_reset`=0, `done`=1. `start` returns to HDR0 and reasserts `cpu_reset` in the same cycle as the transition.
- ERR: `cpu_reset`=1, `error`=1. The only exit is `reset`; `start` is ignored.
- `byte_ready`=1 only in HDR0, HDR1 and LOAD. A `byte_valid` without `byte_ready` is not consumed; the host must hold the byte.
- `imem_addr` never wraps: the count check guarantees the last address is MAX_WORDS−1.
- `start` while loading is ignored; the load in progress continues.

## Timing
- Reset values:
  - state IDLE
  - `cpu_reset`=1
  - `byte_ready`=0, `imem_we`=0
  - `imem_addr`=0, `imem_wd`=0
  - `loading`=0, `done`=0, `error`=0
  - `words_loaded`=0
- Reset asserted mid-load aborts immediately. Memory contents already written are left untouched; no `imem_we` pulse is emitted after reset asserts.
- All outputs are registered or decoded from the state register only. There is no combinational path from `byte_valid` to `byte_ready`.
- Per word: 4 accept cycles + 1 WRITE cycle. Best case for N words is 2 + 5N cycles from the first header byte to RUN.
- `imem_we`, `imem_addr` and `imem_wd` are stable for the whole WRITE cycle. The write commits on the rising edge that ends WRITE.
- `cpu_reset` falls on the edge that enters RUN. The core fetches PC=0 on the following edge.
- `words_loaded` increments on the edge leaving WRITE.

## Structure
- `loader_pkg`: state enum `loader_state_t`, constant `HDR_BYTES`=2, constant `BYTES_PER_WORD`=4.
- Sub-module `byte_packer`: 2-bit lane counter plus a 32-bit shift/insert register.
  - Inputs: `clk`, `reset`, `clr`, `push`, `byte_in`.
  - Outputs: `word`, `full` (asserted after the 4th push).
- The FSM, header count register and address counter stay in `prog_loader`.

## Test plan
- Reset then `start`, bytes 02 00 | 78 56 34 12 | EF BE AD DE → writes 0x12345678 @0 and 0xDEADBEEF @1; `done`=1; `cpu_reset` falls exactly 12 cycles after the first header byte is accepted (no stalls).
- Header 00 00 → RUN two cycles after `start` with no `imem_we` pulse and `words_loaded`=0.
- Header 01 01 (257 > MAX_WORDS) → ERR, `error`=1, `cpu_reset` stays 1; a later `start` has no effect.
- Random `byte_valid` gaps of 0–5 cycles during a 3-word load → identical written words and addresses; no byte lost or duplicated; `byte_ready`=0 during every WRITE cycle.
- Assert `reset` after the 2nd data byte → all outputs return to reset values next cycle; a fresh `start` plus a 1-word load writes @0 correctly.
- In RUN, pulse `start` → `cpu_reset` rises on the same edge as the return to HDR0; `words_loaded` clears; the reload overwrites from address 0.
